uart_tx_scheduler: RTL and testbench

//  Shares the single UART transmitter between two byte sources (CPU, debug).

---
 rtl/uart_tx_scheduler_if.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Byte-request and UART-TX handshake bundle
// shared by the scheduler and its neighbours.
interface uart_tx_scheduler_if;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (
    output req_valid,
    output req_data0,
    output req_data1,
    output tx_done,
    input  req_ready,
    input  tx_start,
    input  tx_data
  );

  modport slave (
    input  req_valid,
    input  req_data0,
    input  req_data1,
    input  tx_done,
    output req_ready,
    output tx_start,
    output tx_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin CPU/debug byte arbiter, FIFO and
// UART TX frame sequencer with gap and timeout.
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1048575
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  uart_tx_scheduler_if.slave bus,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_t;

  state_t state, state_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          rr_ptr;
  logic [1:0]    grant;
  logic          push, pop, full;
  logic [7:0]    push_data;
  logic [7:0]    tx_data_q;
  logic [TW-1:0] tmr, tmr_next;
  logic [GW-1:0] gcnt, gcnt_next;
  logic          err_set;
  logic          busy_next;

  assign full = (count == CW'(FIFO_DEPTH));

  // Only contention consults the pointer;
  // a lone requester is granted directly.
  always_comb begin
    grant = 2'b00;
    if (!reset && !full) begin
      if (&bus.req_valid)
        grant = rr_ptr ? 2'b10 : 2'b01;
      else
        grant = bus.req_valid;
    end
  end

  assign push      = |grant;
  assign push_data = grant[1] ? bus.req_data1
                              : bus.req_data0;

  assign bus.req_ready = grant;
  assign bus.tx_start  = (state == START);
  assign bus.tx_data   = tx_data_q;
  assign fifo_count    = count;

  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    gcnt_next  = gcnt;
    err_set    = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && count != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tmr_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          gcnt_next  = GW'(GAP_CYCLES - 1);
          state_next = GAP;
        end else if (tmr == TW'(TIMEOUT - 1)) begin
          err_set    = 1'b1;
          gcnt_next  = GW'(GAP_CYCLES - 1);
          state_next = GAP;
        end else begin
          tmr_next = tmr + 1'b1;
        end
      end
      GAP: begin
        if (gcnt == '0)
          state_next = IDLE;
        else
          gcnt_next = gcnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign busy_next = (state_next != IDLE) ||
                     (count_next != '0);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rr_ptr      <= 1'b0;
      tx_data_q   <= '0;
      tmr         <= '0;
      gcnt        <= '0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      tmr   <= tmr_next;
      gcnt  <= gcnt_next;
      busy  <= busy_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= grant[0];
      end
      if (pop) begin
        tx_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (err_set)
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler:
// directed arbitration, FIFO, gap and timeout cases.
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic busy;
  logic [2:0] fifo_count;
  logic err_timeout;

  always #5 clk = ~clk;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus),
    .busy(busy),
    .fifo_count(fifo_count),
    .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_starts = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  logic done_pulse = 1'b0;
  logic force_done = 1'b0;
  logic auto_done = 1'b0;
  int done_delay = 10;
  int dcnt = 0;
  int done_cyc = 0;

  assign bus.tx_done = done_pulse | force_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h",
               name, act, exp);
    end
  endtask

  // Scoreboard monitor: every start pulse consumes one expected byte.
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      n_starts++;
      start_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_start: got 0x%0h required none",
                 bus.tx_data);
      end else begin
        chk("tx_data", bus.tx_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    done_pulse <= 1'b0;
    if (bus.tx_start === 1'b1 && auto_done) begin
      dcnt <= done_delay;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        done_pulse <= 1'b1;
        done_cyc   <= cyc;
      end
    end
  end

  task automatic offer(input logic [1:0] v,
                       input logic [7:0] d0,
                       input logic [7:0] d1,
                       output logic [1:0] g);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    #1;
    g = bus.req_ready;
  endtask

  task automatic drop();
    @(negedge clk);
    bus.req_valid = 2'b00;
  endtask

  task automatic wait_start(input int bound, output int c);
    c = -1;
    for (int i = 0; i < bound; i++) begin
      if (start_q.size() != 0) break;
      @(negedge clk);
      #1;
    end
    if (start_q.size() != 0) begin
      c = start_q.pop_front();
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL start_wait: got none required start within %0d", bound);
    end
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_wait: busy=%0b pending=%0d required idle",
               busy, exp_q.size());
    end
    repeat (2) @(negedge clk);
    start_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 2'b00;
    force_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    start_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    logic [1:0] expg [4];
    logic [7:0] cpu, dbg;
    int n, s, s2, e, r, ns, nc, nd;

    bus.req_valid = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;

    // Reset values, with both requesters valid during reset
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_tx_start", bus.tx_start, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_err", err_timeout, 1'b0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    // 1: single byte latency, then gap spacing
    enable = 1'b1;
    auto_done = 1'b1;
    done_delay = 50;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA6);
    offer(2'b01, 8'hA5, 8'h00, g);
    n = cyc;
    chk("single_ready", g, 2'b01);
    offer(2'b01, 8'hA6, 8'h00, g);
    chk("second_ready", g, 2'b01);
    drop();
    chk("busy_active", busy, 1'b1);
    chk("count_one", fifo_count, 3'd1);
    wait_start(10, s);
    chk("start_latency", s - n, 2);
    wait_start(200, s2);
    chk("start_spacing", s2 - done_cyc, GAP + 2);
    wait_idle(200);

    // 2: contention alternates from a fresh pointer
    do_reset();
    done_delay = 5;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h23);
    expg[0] = 2'b01;
    expg[1] = 2'b10;
    expg[2] = 2'b01;
    expg[3] = 2'b10;
    cpu = 8'h11;
    dbg = 8'h22;
    nc = 0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      offer({nd < 2, nc < 2}, cpu, dbg, g);
      chk("rr_grant", g, expg[k]);
      if (g[0]) begin cpu++; nc++; end
      if (g[1]) begin dbg++; nd++; end
    end
    drop();
    wait_idle(400);

    // 3: fill with enable low, then drain
    enable = 1'b0;
    for (int k = 0; k < 5; k++)
      exp_q.push_back(8'hB0 + 8'(k));
    for (int k = 0; k < 5; k++) begin
      offer(2'b01, 8'hB0 + 8'(k), 8'h00, g);
      chk(k < 4 ? "full_accept" : "full_block",
          g, k < 4 ? 2'b01 : 2'b00);
    end
    chk("fifo_full", fifo_count, 3'd4);
    chk("busy_full_idle", busy, 1'b1);
    offer(2'b01, 8'hB4, 8'h00, g);
    chk("full_hold", g, 2'b00);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready == 2'b01) break;
    end
    chk("refill_ready", bus.req_ready, 2'b01);
    chk("refill_count", fifo_count, 3'd3);
    drop();
    wait_idle(600);

    // 5: spurious tx_done in IDLE and in START
    enable = 1'b0;
    done_delay = 30;
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    offer(2'b01, 8'hC0, 8'h00, g);
    offer(2'b01, 8'hC1, 8'h00, g);
    drop();
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("spur_idle_count", fifo_count, 3'd2);
    chk("spur_idle_busy", busy, 1'b1);
    enable = 1'b1;
    e = cyc;
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("spur_no_pop", fifo_count, 3'd1);
    wait_start(5, s);
    chk("enable_start", s - e, 1);
    wait_start(200, s2);
    chk("spur_start_ignored", s2 - s, 30 + GAP + 2);
    wait_idle(200);

    // 4: timeout, recovery, sticky error
    auto_done = 1'b0;
    exp_q.push_back(8'hD0);
    offer(2'b01, 8'hD0, 8'h00, g);
    drop();
    wait_start(5, s);
    r = -1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        r = cyc;
        break;
      end
    end
    chk("timeout_cycle", r - s, TMO + 1);
    auto_done = 1'b1;
    done_delay = 5;
    exp_q.push_back(8'hD1);
    offer(2'b01, 8'hD1, 8'h00, g);
    drop();
    wait_start(60, s2);
    chk("recover_start", s2 - s, TMO + GAP + 2);
    wait_idle(200);
    chk("err_sticky", err_timeout, 1'b1);

    // 6: reset while in WAIT with three bytes queued
    done_delay = 40;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(8'hE0 + 8'(k));
    for (int k = 0; k < 4; k++)
      offer(2'b01, 8'hE0 + 8'(k), 8'h00, g);
    drop();
    wait_start(10, s);
    repeat (3) @(negedge clk);
    chk("pre_reset_count", fifo_count, 3'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    chk("post_reset_count", fifo_count, 3'd0);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_err", err_timeout, 1'b0);
    chk("post_reset_data", bus.tx_data, 8'h00);
    ns = n_starts;
    repeat (80) @(negedge clk);
    chk("no_start_after_reset", n_starts, ns);
    chk("idle_after_reset", busy, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
